// File: rtl/cim_sar_sequencer_if.sv
// Command/result bus between the pin decoder and the CIM SAR sequencer.
// The sequencer uses the slave modport; the pin decoder uses master.
interface cim_sar_sequencer_if #(
   parameter int ROW_AW   = 2,
   parameter int COLS     = 8,
   parameter int ADC_BITS = 4
) ();
   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_op;
   logic [ROW_AW-1:0]   cmd_row;
   logic [COLS-1:0]     cmd_data;
   logic                res_valid;
   logic [ADC_BITS-1:0] res_data;
   logic                busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_row, cmd_data,
      output cmd_ready, res_valid, res_data, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_row, cmd_data,
      input  cmd_ready, res_valid, res_data, busy
   );
endinterface

// File: rtl/cim_sar_sequencer.sv
// Sequences the analog CIM macro: weight-row writes, and compute =
// precharge -> evaluate -> SAR readout of the macro comparator.
//
// state  | meaning
// IDLE   | ready for a command
// WRITE  | wordline + write enable held for T_WR cycles
// PRE    | bitline precharge for T_PRE cycles
// EVAL   | activations on wordlines, charge share for T_EVAL cycles
// SAR    | one trial bit per T_SET cycles, MSB first
// DONE   | result published, one-cycle res_valid
module cim_sar_sequencer #(
   parameter int ROW_AW   = 2,
   parameter int COLS     = 8,
   parameter int ADC_BITS = 4,
   parameter int T_WR     = 2,
   parameter int T_PRE    = 2,
   parameter int T_EVAL   = 3,
   parameter int T_SET    = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   cim_sar_sequencer_if.slave     bus,
   output logic                   macro_pre,
   output logic [2**ROW_AW-1:0]   macro_wl,
   output logic                   macro_we,
   output logic [COLS-1:0]        macro_wdata,
   output logic                   macro_eval,
   output logic [ADC_BITS-1:0]    dac_code,
   input  logic                   comp_in
);
   localparam int N_ROWS = 2**ROW_AW;
   localparam int TM1    = (T_WR > T_PRE) ? T_WR : T_PRE;
   localparam int TM2    = (T_EVAL > T_SET) ? T_EVAL : T_SET;
   localparam int TMAX   = (TM1 > TM2) ? TM1 : TM2;
   localparam int CW     = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int BW     = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_PRE, S_EVAL, S_SAR, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [ADC_BITS-1:0] code_q, code_d;
   logic [ADC_BITS-1:0] res_q, res_d;
   logic [ROW_AW-1:0]   row_q, row_d;
   logic [COLS-1:0]     data_q, data_d;
   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic [ADC_BITS-1:0] trial;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         code_q  <= '0;
         res_q   <= '0;
         row_q   <= '0;
         data_q  <= '0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         code_q  <= code_d;
         res_q   <= res_d;
         row_q   <= row_d;
         data_q  <= data_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      code_d      = code_q;
      res_d       = res_q;
      row_d       = row_q;
      data_d      = data_q;
      sync1_d     = comp_in;
      sync2_d     = sync1_q;
      trial       = code_q | (ADC_BITS'(1) << bit_q);
      bus.cmd_ready = 1'b0;
      bus.res_valid = 1'b0;
      macro_pre   = 1'b0;
      macro_wl    = '0;
      macro_we    = 1'b0;
      macro_wdata = '0;
      macro_eval  = 1'b0;
      dac_code    = '0;

      case (state_q)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               row_d  = bus.cmd_row;
               data_d = bus.cmd_data;
               if (bus.cmd_op) begin
                  state_d = S_PRE;
                  cnt_d   = CW'(T_PRE - 1);
               end else begin
                  state_d = S_WRITE;
                  cnt_d   = CW'(T_WR - 1);
               end
            end
         end
         S_WRITE: begin
            macro_wl    = N_ROWS'(1) << row_q;
            macro_we    = 1'b1;
            macro_wdata = data_q;
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_PRE: begin
            macro_pre = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_EVAL;
               cnt_d   = CW'(T_EVAL - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_EVAL: begin
            macro_wl   = data_q[N_ROWS-1:0];
            macro_eval = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_SAR;
               cnt_d   = CW'(T_SET - 1);
               bit_d   = BW'(ADC_BITS - 1);
               code_d  = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_SAR: begin
            macro_wl   = data_q[N_ROWS-1:0];
            macro_eval = 1'b1;
            dac_code   = trial;
            // comparator is only trusted on the last cycle, after DAC settle + sync
            if (cnt_q == '0) begin
               code_d = sync2_q ? trial : code_q;
               if (bit_q == '0) begin
                  state_d = S_DONE;
                  res_d   = code_d;
               end else begin
                  bit_d = bit_q - BW'(1);
                  cnt_d = CW'(T_SET - 1);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            bus.res_valid = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.res_data = res_q;
   assign bus.busy     = ~bus.cmd_ready;
endmodule

// File: doc/cim_sar_sequencer.md
Name: cim_sar_sequencer

Overview:
Controller that sequences the analog compute-in-memory macro on the analog pins. It accepts one command at a time over a valid/ready interface: either a weight-row write or an in-memory compute. A compute runs the precharge phase, then the evaluate phase, then a successive-approximation readout of the macro comparator through a DAC reference code. The block sits between the digital pin decoder and the analog macro control lines.

Parameters:
ROW_AW, 2, row address width; N_ROWS = 2**ROW_AW wordlines
COLS, 8, weight word width (bitline columns)
ADC_BITS, 4, SAR result width
T_WR, 2, cycles wordline+write-enable held per weight write (>=1)
T_PRE, 2, precharge cycles (>=1)
T_EVAL, 3, evaluate/charge-share cycles before SAR (>=1)
T_SET, 3, cycles per SAR trial bit, DAC settle plus synchroniser (>=3)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, can accept a command
cmd_op  in  1  0=write weight row, 1=compute
cmd_row  in  ROW_AW  target row for writes (ignored for compute)
cmd_data  in  COLS  weight word (write); bits [N_ROWS-1:0] = input activation vector (compute)
macro_pre  out  1  bitline precharge
macro_wl  out  N_ROWS  wordline enables
macro_we  out  1  macro write enable
macro_wdata  out  COLS  write data to macro
macro_eval  out  1  evaluate / charge-share enable
dac_code  out  ADC_BITS  SAR reference code to the macro DAC
comp_in  in  1  asynchronous comparator output; 1 = bitline above reference
res_valid  out  1  one-cycle pulse, result available
res_data  out  ADC_BITS  last conversion result
busy  out  1  ~cmd_ready

Behaviour:
- All registers update on rising clk. rst_n=0 at an edge puts the block in IDLE. The following are cleared to 0: all outputs, sync flops, SAR code and res_data. cmd_ready=1 after reset.
- comp_in passes through a 2-flop synchroniser (comp_s) before use.
- Handshake: a command is accepted only when cmd_valid&cmd_ready, i.e. in IDLE. cmd_ready=0 in every other state. Commands presented while busy are ignored, not queued. cmd_row and cmd_data are latched at acceptance.
- FSM states: IDLE, WRITE, PRE, EVAL, SAR, DONE.
- IDLE -> WRITE (op=0) or PRE (op=1) on the accept edge.
- WRITE, T_WR cycles: macro_wl=onehot(row), macro_we=1, macro_wdata=data. Then -> IDLE. No res_valid.
- PRE, T_PRE cycles: macro_pre=1, macro_wl=0, macro_eval=0. Then -> EVAL.
- EVAL, T_EVAL cycles: macro_wl=latched activation bits, macro_eval=1. Then -> SAR. macro_wl and macro_eval stay held throughout SAR.
- SAR processes bit i from ADC_BITS-1 down to 0, T_SET cycles per bit. During each trial, dac_code = code | (1<<i). On the last cycle of the trial, sample comp_s: 1 keeps bit i, 0 clears it. After bit 0 -> DONE.
- DONE, 1 cycle: res_data<=code, res_valid=1. macro_wl, macro_eval and dac_code return to 0. Then -> IDLE.
- Compute latency: res_valid is high exactly 1+T_PRE+T_EVAL+ADC_BITS*T_SET cycles after the accept cycle. With defaults this is 18.
- Write latency: cmd_ready returns T_WR+1 cycles after accept.
- macro_we and macro_pre are never high together. macro_we is never high in PRE/EVAL/SAR.
- res_data holds its value until the next DONE. A write command does not change res_data.
- An all-zero activation vector still runs the full sequence.
- Reset mid-operation (any state): abort. No res_valid. res_data is cleared. All macro controls drop on that edge.
- Per-state cycle counter width is sized for max(T_*). The counter reloads on every state entry.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with cmd_valid=1 -> all outputs 0, cmd_ready=1, no command accepted.
- Write row 2, data 0xA5 -> macro_wl=4'b0100, macro_we=1, macro_wdata=0xA5 for exactly 2 cycles. cmd_ready returns 3 cycles after accept. res_valid stays 0.
- Compute, act=4'b1011. Comparator model outputs 1 iff dac_code<=9 -> macro_pre 2 cycles, then macro_wl=1011 with eval. dac_code trials 8,12,10,9. res_data=9 with res_valid pulse at accept+18.
- Comparator stuck 0 -> res_data=0. Stuck 1 -> res_data=15. Trial sequence 8,4,2,1 and 8,12,14,15 respectively.
- Back-to-back: cmd_valid held high with a compute then a write queued -> second command accepted on the first IDLE cycle after DONE; nothing is accepted while busy.
- Reset asserted during SAR bit 1 -> next cycle in IDLE, controls 0, res_data=0, no res_valid pulse. A following compute completes normally.
